// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 stream demultiplexer slice.
package demux_pkg;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;
endpackage

// File: rtl/demux_ch_reg.sv
// One output channel: a single-entry holding register plus a delivered-beat counter.
module demux_ch_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [CNT_W-1:0]  cnt
);
  logic xfer;

  assign xfer = valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
      cnt   <= '0;
    end else begin
      // a load in the same cycle as a drain keeps valid asserted
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
        last  <= load_last;
      end else if (xfer) begin
        valid <= 1'b0;
      end
      if (xfer) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/demux1_4_stream.sv
// Registered 1:4 stream demultiplexer; the destination is chosen on a packet's
// first beat and held until its last beat.
module demux1_4_stream
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [DATA_W-1:0]    a_in,
  input  logic                 a_valid_in,
  input  logic                 a_last_in,
  output logic                 a_ready_out,
  input  logic [SEL_W-1:0]     sel_in,
  output logic [4*DATA_W-1:0]  y_out,
  output logic [3:0]           y_valid_out,
  output logic [3:0]           y_last_out,
  input  logic [3:0]           y_ready_in,
  output logic [4*CNT_W-1:0]   cnt_out,
  output logic                 busy_out
);
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [SEL_W-1:0]   tgt;
  logic               accept;
  logic [NUM_CH-1:0]  load;

  always_comb begin
    tgt         = (state_q == IDLE) ? sel_in : ch_q;
    a_ready_out = ~y_valid_out[tgt] | y_ready_in[tgt];
    accept      = a_valid_in & a_ready_out;
  end

  assign busy_out = (state_q == ROUTE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (accept && !a_last_in) begin
          state_d = ROUTE;
          ch_d    = sel_in;
        end
      end
      ROUTE: begin
        if (accept && a_last_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = accept & (tgt == SEL_W'(k));

    demux_ch_reg #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk       (clk_in),
      .rst       (rst_in),
      .load      (load[k]),
      .load_data (a_in),
      .load_last (a_last_in),
      .ready     (y_ready_in[k]),
      .valid     (y_valid_out[k]),
      .data      (y_out[k*DATA_W +: DATA_W]),
      .last      (y_last_out[k]),
      .cnt       (cnt_out[k*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_demux1_4_stream.sv
// Self-checking bench: behavioural channel model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_demux1_4_stream;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic          a_valid = 1'b0;
  logic          a_last = 1'b0;
  logic          a_ready;
  logic [1:0]    sel = '0;
  logic [4*DW-1:0] y_out;
  logic [3:0]    y_valid;
  logic [3:0]    y_last;
  logic [3:0]    y_ready = 4'hF;
  logic [4*CW-1:0] cnt_out;
  logic          busy;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  bit          chk_en  = 1'b0;

  demux1_4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .a_in        (a_in),
    .a_valid_in  (a_valid),
    .a_last_in   (a_last),
    .a_ready_out (a_ready),
    .sel_in      (sel),
    .y_out       (y_out),
    .y_valid_out (y_valid),
    .y_last_out  (y_last),
    .y_ready_in  (y_ready),
    .cnt_out     (cnt_out),
    .busy_out    (busy)
  );

  always #5 clk = ~clk;

  // Model: each channel holds the most recent beat routed to it until taken;
  // a packet is in progress iff the last accepted beat was not a last beat.
  logic [3:0]    m_v;
  logic [3:0]    m_l;
  logic [DW-1:0] m_d [4];
  int unsigned   m_tot [4];
  logic          m_busy;
  logic [1:0]    m_ch;
  logic [1:0]    m_tgt;
  logic          m_rdy;
  logic          m_acc;

  assign m_tgt = m_busy ? m_ch : sel;
  assign m_rdy = !m_v[m_tgt] || y_ready[m_tgt];
  assign m_acc = a_valid && m_rdy;

  always @(posedge clk) begin
    if (rst) begin
      m_v    <= '0;
      m_l    <= '0;
      m_busy <= 1'b0;
      m_ch   <= '0;
      for (int k = 0; k < 4; k++) begin
        m_d[k]   <= '0;
        m_tot[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_v[k] && y_ready[k]) m_tot[k] <= m_tot[k] + 1;
        if (m_acc && m_tgt == k) begin
          m_v[k] <= 1'b1;
          m_d[k] <= a_in;
          m_l[k] <= a_last;
        end else if (m_v[k] && y_ready[k]) begin
          m_v[k] <= 1'b0;
        end
      end
      if (m_acc) begin
        m_busy <= !a_last;
        if (!m_busy) m_ch <= sel;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 64'(y_valid), 64'(m_v));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("ready", 64'(a_ready), 64'(m_rdy));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("cnt%0d", k), 64'(cnt_out[k*CW +: CW]), 64'(m_tot[k] % (1 << CW)));
        if (m_v[k]) begin
          chk($sformatf("data%0d", k), 64'(y_out[k*DW +: DW]), 64'(m_d[k]));
          chk($sformatf("last%0d", k), 64'(y_last[k]), 64'(m_l[k]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [1:0] s, input logic [DW-1:0] d, input logic l);
    sel = s; a_in = d; a_last = l; a_valid = 1'b1;
  endtask

  task automatic pulse_reset();
    a_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc(); cyc();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_valid", 64'(y_valid), 64'h0);
    chk("rst_yout", 64'(y_out), 64'h0);
    chk("rst_cnt", 64'(cnt_out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // single-beat packets to every channel
    y_ready = 4'hF;
    for (int s = 0; s < 4; s++) begin
      beat(2'(s), 8'(8'h30 + s), 1'b1);
      cyc();
      if (s == 0) begin
        chk("sb_valid0", 64'(y_valid), 64'h1);
        chk("sb_data0", 64'(y_out[7:0]), 64'h30);
      end
      chk("sb_busy", 64'(busy), 64'h0);
    end
    a_valid = 1'b0;
    cyc(); cyc();
    chk("sb_cnt", 64'(cnt_out), 64'h01010101);

    // select lock on a 4-beat packet
    pulse_reset();
    beat(2'd2, 8'h11, 1'b0); cyc();
    chk("lock_busy1", 64'(busy), 64'h1);
    beat(2'd0, 8'h12, 1'b0); cyc();
    beat(2'd3, 8'h13, 1'b0); cyc();
    beat(2'd0, 8'h14, 1'b1); cyc();
    chk("lock_busy4", 64'(busy), 64'h0);
    chk("lock_valid", 64'(y_valid), 64'h4);
    chk("lock_data", 64'(y_out[23:16]), 64'h14);
    a_valid = 1'b0; cyc();
    chk("lock_cnt", 64'(cnt_out), 64'h00040000);

    // reset in the middle of a packet
    pulse_reset();
    beat(2'd2, 8'h21, 1'b0); cyc();
    beat(2'd2, 8'h22, 1'b0); rst = 1'b1; cyc();
    rst = 1'b0;
    chk("mid_valid", 64'(y_valid), 64'h0);
    chk("mid_cnt", 64'(cnt_out), 64'h0);
    chk("mid_busy", 64'(busy), 64'h0);
    beat(2'd1, 8'h77, 1'b1); cyc();
    chk("mid_valid1", 64'(y_valid), 64'h2);
    chk("mid_data1", 64'(y_out[15:8]), 64'h77);
    a_valid = 1'b0; cyc();

    // backpressure on ch1 while ch3 keeps flowing
    pulse_reset();
    y_ready = 4'b1101;
    beat(2'd1, 8'h40, 1'b1); cyc();
    beat(2'd3, 8'h60, 1'b0); cyc();
    beat(2'd1, 8'h61, 1'b1); cyc();
    chk("bp_ch3", 64'(y_out[31:24]), 64'h61);
    beat(2'd1, 8'h41, 1'b1);
    #1;
    chk("bp_ready0", 64'(a_ready), 64'h0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_hold", 64'(y_out[15:8]), 64'h40);
      chk("bp_ready", 64'(a_ready), 64'h0);
    end
    y_ready = 4'hF;
    #1;
    chk("bp_ready1", 64'(a_ready), 64'h1);
    cyc();
    chk("bp_new", 64'(y_out[15:8]), 64'h41);
    chk("bp_cnt", 64'(cnt_out), 64'h02000100);
    a_valid = 1'b0; cyc();

    // drain and load of ch0 in the same cycle
    pulse_reset();
    beat(2'd0, 8'h5A, 1'b1); cyc();
    beat(2'd0, 8'hA5, 1'b1); cyc();
    chk("dl_valid", 64'(y_valid[0]), 64'h1);
    chk("dl_data", 64'(y_out[7:0]), 64'hA5);
    chk("dl_cnt", 64'(cnt_out[7:0]), 64'h1);
    a_valid = 1'b0; cyc();

    // counter wrap on ch3
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      beat(2'd3, 8'(i), (i == 255));
      cyc();
    end
    chk("wrap_255", 64'(cnt_out[31:24]), 64'hFF);
    a_valid = 1'b0; cyc();
    chk("wrap_0", 64'(cnt_out[31:24]), 64'h0);
    beat(2'd3, 8'hEE, 1'b1); cyc();
    a_valid = 1'b0; cyc();
    chk("wrap_1", 64'(cnt_out[31:24]), 64'h1);

    // randomized traffic
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      a_last  = ($urandom_range(0, 3) == 0);
      sel     = 2'($urandom_range(0, 3));
      a_in    = 8'($urandom);
      y_ready = 4'($urandom);
      rst     = ($urandom_range(0, 255) == 0);
      cyc();
    end
    rst = 1'b0; a_valid = 1'b0; y_ready = 4'hF;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
